// File: rtl/low_power_instr_issue.sv
// ============================================================================
// low_power_instr_issue : FIFO-buffered issue stage with bubbles, illegal drop
// Revision 1.0
// ============================================================================
`default_nettype none

module low_power_instr_issue #(
  parameter int DEPTH          = 4,
  parameter int BRANCH_BUBBLES = 2,
  parameter int LOAD_BUBBLES   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_opcode,
  output logic        in_ready,
  input  logic        flush,
  input  logic        stall,
  output logic [3:0]  opcode,
  output logic        valid,
  output logic        illegal,
  output logic        idle,
  output logic [15:0] issued
);

  localparam int            AW          = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_COUNT   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR     = AW'(1);
  localparam logic [2:0]    BRANCH_LOAD = 3'(BRANCH_BUBBLES);
  localparam logic [2:0]    LOAD_LOAD   = 3'(LOAD_BUBBLES);
  localparam logic [3:0]    OP_LOAD     = 4'b0110;
  localparam logic [3:0]    OP_BRANCH   = 4'b1000;
  localparam logic [3:0]    OP_JUMP     = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_BUBBLE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [2:0]    bcnt;
  logic [2:0]    bcnt_next;
  logic [2:0]    bubble_load;
  logic [3:0]    head;
  logic          head_legal;
  logic          push;
  logic          pop;
  logic          issue_now;
  logic          drop_now;

  assign in_ready   = (count != FULL_COUNT);
  assign idle       = (state == S_IDLE);
  assign head       = mem[rd_ptr];
  assign head_legal = (head[3:2] != 2'b11);

  // in_ready comes from the registered count, so a simultaneous pop never frees a slot for a push.
  assign push      = in_valid && in_ready && !flush;
  assign pop       = !flush && !stall && (state != S_BUBBLE) && (count != '0);
  assign issue_now = pop && head_legal;
  assign drop_now  = pop && !head_legal;

  always_comb begin
    bubble_load = 3'd0;
    if (head == OP_BRANCH || head == OP_JUMP) begin
      bubble_load = BRANCH_LOAD;
    end else if (head == OP_LOAD) begin
      bubble_load = LOAD_LOAD;
    end
  end

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + ONE_COUNT;
        2'b01:   count_next = count - ONE_COUNT;
        default: count_next = count;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    bcnt_next  = bcnt;
    if (flush) begin
      state_next = S_IDLE;
      bcnt_next  = 3'd0;
    end else if (state == S_BUBBLE) begin
      // Bubbles keep counting through stalls; leaving depends on what the FIFO holds next.
      bcnt_next = (bcnt != 3'd0) ? bcnt - 3'd1 : 3'd0;
      if (bcnt <= 3'd1) begin
        state_next = (count_next != '0) ? S_ISSUE : S_IDLE;
      end
    end else if (issue_now && bubble_load != 3'd0) begin
      state_next = S_BUBBLE;
      bcnt_next  = bubble_load;
    end else begin
      state_next = (count_next != '0) ? S_ISSUE : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_opcode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      bcnt   <= 3'd0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_next;
      bcnt  <= bcnt_next;
      count <= count_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + ONE_PTR;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + ONE_PTR;
        end
      end
    end
  end

  // opcode only moves on an actual issue, keeping the control-unit bus quiet otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode  <= 4'd0;
      valid   <= 1'b0;
      illegal <= 1'b0;
      issued  <= 16'd0;
    end else begin
      valid   <= issue_now;
      illegal <= drop_now;
      if (issue_now) begin
        opcode <= head;
        issued <= issued + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_low_power_instr_issue.sv
// ============================================================================
// tb_low_power_instr_issue : directed self-checking bench for the issue stage
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_low_power_instr_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_opcode;
  logic        in_ready;
  logic        flush;
  logic        stall;
  logic [3:0]  opcode;
  logic        valid;
  logic        illegal;
  logic        idle;
  logic [15:0] issued;

  int checks;
  int errors;

  low_power_instr_issue #(
    .DEPTH          (4),
    .BRANCH_BUBBLES (2),
    .LOAD_BUBBLES   (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_opcode (in_opcode),
    .in_ready  (in_ready),
    .flush     (flush),
    .stall     (stall),
    .opcode    (opcode),
    .valid     (valid),
    .illegal   (illegal),
    .idle      (idle),
    .issued    (issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = 4'd0;
    flush     = 1'b0;
    stall     = 1'b0;
    #2;
    chk("rst_opcode", 16'(opcode), 16'h0);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_illegal", 16'(illegal), 16'h0);
    chk("rst_issued", issued, 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_idle", 16'(idle), 16'h1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back issue: 0001,0010,0011
    in_valid = 1'b1; in_opcode = 4'b0001;
    tick();
    chk("t1_lat_valid0", 16'(valid), 16'h0);
    in_opcode = 4'b0010;
    tick();
    chk("t1_v1", 16'(valid), 16'h1);
    chk("t1_op1", 16'(opcode), 16'h1);
    in_opcode = 4'b0011;
    tick();
    chk("t1_v2", 16'(valid), 16'h1);
    chk("t1_op2", 16'(opcode), 16'h2);
    in_valid = 1'b0;
    tick();
    chk("t1_v3", 16'(valid), 16'h1);
    chk("t1_op3", 16'(opcode), 16'h3);
    chk("t1_idle", 16'(idle), 16'h1);
    tick();
    chk("t1_v_after", 16'(valid), 16'h0);
    chk("t1_op_hold", 16'(opcode), 16'h3);
    chk("t1_issued", issued, 16'd3);

    // BRANCH then 0001: two bubbles
    in_valid = 1'b1; in_opcode = 4'b1000;
    tick();
    in_opcode = 4'b0001;
    tick();
    in_valid = 1'b0;
    chk("t2_br_valid", 16'(valid), 16'h1);
    chk("t2_br_op", 16'(opcode), 16'h8);
    tick();
    chk("t2_b1_valid", 16'(valid), 16'h0);
    chk("t2_b1_op", 16'(opcode), 16'h8);
    chk("t2_b1_idle", 16'(idle), 16'h0);
    tick();
    chk("t2_b2_valid", 16'(valid), 16'h0);
    chk("t2_b2_op", 16'(opcode), 16'h8);
    tick();
    chk("t2_next_valid", 16'(valid), 16'h1);
    chk("t2_next_op", 16'(opcode), 16'h1);
    tick();
    chk("t2_end_valid", 16'(valid), 16'h0);
    chk("t2_issued", issued, 16'd5);

    // LOAD then 0111: one bubble; then illegal 1101
    in_valid = 1'b1; in_opcode = 4'b0110;
    tick();
    in_opcode = 4'b0111;
    tick();
    in_valid = 1'b0;
    chk("t3_ld_valid", 16'(valid), 16'h1);
    chk("t3_ld_op", 16'(opcode), 16'h6);
    tick();
    chk("t3_bub_valid", 16'(valid), 16'h0);
    tick();
    chk("t3_next_valid", 16'(valid), 16'h1);
    chk("t3_next_op", 16'(opcode), 16'h7);
    in_valid = 1'b1; in_opcode = 4'b1101;
    tick();
    in_valid = 1'b0;
    chk("t3_pre_valid", 16'(valid), 16'h0);
    chk("t3_pre_illegal", 16'(illegal), 16'h0);
    tick();
    chk("t3_ill_pulse", 16'(illegal), 16'h1);
    chk("t3_ill_valid", 16'(valid), 16'h0);
    chk("t3_ill_op", 16'(opcode), 16'h7);
    chk("t3_ill_issued", issued, 16'd7);
    tick();
    chk("t3_ill_clear", 16'(illegal), 16'h0);

    // Stall while pushing five opcodes
    stall = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_opcode = 4'(i);
      tick();
      chk("t4_stall_valid", 16'(valid), 16'h0);
      chk("t4_in_ready", 16'(in_ready), (i >= 4) ? 16'h0 : 16'h1);
    end
    stall = 1'b0; in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t4_drain_valid", 16'(valid), 16'h1);
      chk("t4_drain_op", 16'(opcode), 16'(i));
    end
    chk("t4_idle", 16'(idle), 16'h1);
    tick();
    chk("t4_no5th", 16'(valid), 16'h0);
    chk("t4_issued", issued, 16'd11);

    // Flush a full FIFO with a concurrent push attempt
    stall = 1'b1; in_valid = 1'b1; in_opcode = 4'b0011;
    repeat (4) tick();
    chk("t5_full", 16'(in_ready), 16'h0);
    flush = 1'b1; in_opcode = 4'b0101;
    tick();
    flush = 1'b0; in_valid = 1'b0; stall = 1'b0;
    chk("t5_valid", 16'(valid), 16'h0);
    chk("t5_idle", 16'(idle), 16'h1);
    chk("t5_in_ready", 16'(in_ready), 16'h1);
    chk("t5_op_hold", 16'(opcode), 16'h4);
    tick();
    tick();
    chk("t5_nothing_valid", 16'(valid), 16'h0);
    // Partially filled FIFO: the concurrent push must be discarded too
    stall = 1'b1; in_valid = 1'b1; in_opcode = 4'b0011;
    tick();
    flush = 1'b1; in_opcode = 4'b0101;
    tick();
    flush = 1'b0; in_valid = 1'b0; stall = 1'b0;
    tick();
    tick();
    chk("t5b_discard_valid", 16'(valid), 16'h0);
    chk("t5b_idle", 16'(idle), 16'h1);
    chk("t5b_issued", issued, 16'd11);

    // Issued counter wrap via NOPs
    in_valid = 1'b1; in_opcode = 4'b0000;
    repeat (65524) tick();
    tick();
    in_valid = 1'b0;
    chk("t6_max", issued, 16'hFFFF);
    chk("t6_nop_valid", 16'(valid), 16'h1);
    tick();
    chk("t6_wrap", issued, 16'h0000);
    chk("t6_wrap_valid", 16'(valid), 16'h1);
    tick();
    chk("t6_end_idle", 16'(idle), 16'h1);

    // Reset asserted mid-bubble
    in_valid = 1'b1; in_opcode = 4'b1001;
    tick();
    in_opcode = 4'b0001;
    tick();
    in_valid = 1'b0;
    chk("t7_jump_op", 16'(opcode), 16'h9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_opcode", 16'(opcode), 16'h0);
    chk("t7_valid", 16'(valid), 16'h0);
    chk("t7_illegal", 16'(illegal), 16'h0);
    chk("t7_issued", issued, 16'h0);
    chk("t7_idle", 16'(idle), 16'h1);
    chk("t7_in_ready", 16'(in_ready), 16'h1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t7_lost_valid", 16'(valid), 16'h0);
    chk("t7_lost_issued", issued, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
